// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two requesters.
// Supports bounded ownership locks for atomic read-modify-write sequences.
module ram_arbiter #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic          lock_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_writeOn,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK - 1);

  state_t        state;
  logic          rr_b;       // 1 = B preferred on a tie
  logic [3:0]    lock_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic       win_a, win_b;
  logic       owner_hit, lock_win, can_lock;
  logic [3:0] cnt_base;

  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (rst_n) begin
      if (state == OWN_A && req_a) begin
        win_a = 1'b1;
      end else if (state == OWN_B && req_b) begin
        win_b = 1'b1;
      end else if (req_a && req_b) begin
        win_a = !rr_b;
        win_b = rr_b;
      end else begin
        win_a = req_a;
        win_b = req_b;
      end
    end
  end

  // The lock count only carries over while the same owner keeps winning.
  always_comb begin
    owner_hit = (state == OWN_A && win_a) || (state == OWN_B && win_b);
    cnt_base  = owner_hit ? lock_cnt : '0;
    lock_win  = (win_a && lock_a) || (win_b && lock_b);
    can_lock  = lock_win && (cnt_base < LOCK_LIMIT);
  end

  always_comb begin
    mem_writeOn = 1'b0;
    mem_address = addr_q;
    mem_data_in = wdata_q;
    if (win_a) begin
      mem_writeOn = we_a;
      mem_address = addr_a;
      mem_data_in = wdata_a;
    end else if (win_b) begin
      mem_writeOn = we_b;
      mem_address = addr_b;
      mem_data_in = wdata_b;
    end
  end

  assign gnt_a   = win_a;
  assign gnt_b   = win_b;
  assign rdata_a = mem_data_out;
  assign rdata_b = mem_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_b     <= 1'b0;
      lock_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= win_a && !we_a;
      rvalid_b <= win_b && !we_b;
      if (win_a || win_b) begin
        addr_q  <= mem_address;
        wdata_q <= mem_data_in;
        // Every grant points the tie-break at the loser, which also hands
        // over ownership when a lock expires.
        rr_b    <= win_a;
      end
      if (can_lock) begin
        state    <= win_a ? OWN_A : OWN_B;
        lock_cnt <= cnt_base + 4'd1;
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural write-first registered-read RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        mem_writeOn;
  logic [4:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;

  logic [31:0] ram [32];
  logic        preload;
  int          checks = 0;
  int          errors = 0;
  logic [6:0]  lock_pat;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(5), .DW(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_writeOn(mem_writeOn), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'(i);
      mem_data_out <= '0;
    end else begin
      if (mem_writeOn) ram[mem_address] <= mem_data_in;
      mem_data_out <= mem_writeOn ? mem_data_in : ram[mem_address];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic r, input logic w, input logic l, input logic [4:0] a, input logic [31:0] d);
    req_a = r; we_a = w; lock_a = l; addr_a = a; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic l, input logic [4:0] a, input logic [31:0] d);
    req_b = r; we_b = w; lock_b = l; addr_b = a; wdata_b = d;
  endtask

  initial begin
    preload = 1'b1;
    rst_n   = 1'b0;
    set_a(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234_5678);
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    tick();
    tick();
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_we", mem_writeOn, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    preload = 1'b0;
    rst_n   = 1'b1;
    tick();

    // A reads addr 3 alone
    set_a(1'b1, 1'b0, 1'b0, 5'd3, '0);
    #1;
    chk("t1_gnt_a", gnt_a, 1);
    chk("t1_gnt_b", gnt_b, 0);
    chk("t1_addr", mem_address, 3);
    chk("t1_we", mem_writeOn, 0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t1_rvalid_a", rvalid_a, 1);
    chk("t1_rdata_a", rdata_a, 32'h0000_0003);
    chk("t1_rvalid_b", rvalid_b, 0);
    chk("t1_idle_we", mem_writeOn, 0);
    chk("t1_idle_addr_hold", mem_address, 3);
    tick();

    // B reads addr 5 alone, tie-break returns to A
    set_b(1'b1, 1'b0, 1'b0, 5'd5, '0);
    #1;
    chk("b5_gnt_b", gnt_b, 1);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("b5_rvalid_b", rvalid_b, 1);
    chk("b5_rdata_b", rdata_b, 5);
    tick();

    // Both reading for 4 cycles: A,B,A,B
    set_a(1'b1, 1'b0, 1'b0, 5'd1, '0);
    set_b(1'b1, 1'b0, 1'b0, 5'd2, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt_a", gnt_a, 32'(i % 2 == 0));
      chk("t2_gnt_b", gnt_b, 32'(i % 2 == 1));
      if (i > 0) begin
        chk("t2_rvalid_a", rvalid_a, 32'(i % 2 == 1));
        chk("t2_rvalid_b", rvalid_b, 32'(i % 2 == 0));
        chk("t2_rdata", rdata_a, (i % 2 == 1) ? 32'd1 : 32'd2);
      end
      tick();
    end
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t2_last_rvalid_b", rvalid_b, 1);
    chk("t2_last_rvalid_a", rvalid_a, 0);
    chk("t2_last_rdata_b", rdata_b, 2);
    tick();

    // A read so that the tie-break points at B
    set_a(1'b1, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("a0_gnt_a", gnt_a, 1);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("a0_rvalid_a", rvalid_a, 1);
    chk("a0_rdata_a", rdata_a, 0);
    tick();

    // B writes addr 7 while A reads addr 7
    set_a(1'b1, 1'b0, 1'b0, 5'd7, '0);
    set_b(1'b1, 1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF);
    #1;
    chk("t3_gnt_b", gnt_b, 1);
    chk("t3_gnt_a", gnt_a, 0);
    chk("t3_we", mem_writeOn, 1);
    chk("t3_addr", mem_address, 7);
    chk("t3_din", mem_data_in, 32'hDEAD_BEEF);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t3_gnt_a2", gnt_a, 1);
    chk("t3_we2", mem_writeOn, 0);
    chk("t3_wr_no_rvalid_b", rvalid_b, 0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t3_rvalid_a", rvalid_a, 1);
    chk("t3_rdata_a", rdata_a, 32'hDEAD_BEEF);
    tick();

    // B reads addr 7, tie-break back to A
    set_b(1'b1, 1'b0, 1'b0, 5'd7, '0);
    #1;
    chk("b7_gnt_b", gnt_b, 1);
    tick();
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("b7_rdata_b", rdata_b, 32'hDEAD_BEEF);
    tick();

    // Lock: A A A A (expiry) B, then lock dropped: A B
    lock_pat = 7'b0101111;
    set_a(1'b1, 1'b0, 1'b1, 5'd4, '0);
    set_b(1'b1, 1'b0, 1'b0, 5'd6, '0);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) lock_a = 1'b0;
      #1;
      chk("t4_gnt_a", gnt_a, 32'(lock_pat[i]));
      chk("t4_gnt_b", gnt_b, 32'(!lock_pat[i]));
      if (i > 0) chk("t4_rvalid_a", rvalid_a, 32'(lock_pat[i-1]));
      tick();
    end
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t4_rvalid_b", rvalid_b, 1);
    chk("t4_rdata_b", rdata_b, 6);
    tick();

    // Write-only traffic with idle cycles in between
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 1'b0, 5'(10 + i), 32'hA000_0000 + 32'(i));
      #1;
      chk("t5_gnt_a", gnt_a, 1);
      chk("t5_we_a", mem_writeOn, 1);
      tick();
      set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
      #1;
      chk("t5_idle_we", mem_writeOn, 0);
      chk("t5_rvalid_a", rvalid_a, 0);
      chk("t5_hold_addr", mem_address, 32'(10 + i));
      chk("t5_hold_din", mem_data_in, 32'hA000_0000 + 32'(i));
      tick();
      set_b(1'b1, 1'b1, 1'b0, 5'(20 + i), 32'hB000_0000 + 32'(i));
      #1;
      chk("t5_gnt_b", gnt_b, 1);
      chk("t5_we_b", mem_writeOn, 1);
      tick();
      set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
      #1;
      chk("t5_idle_we_b", mem_writeOn, 0);
      chk("t5_rvalid_b", rvalid_b, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, 1'b0, 5'(10 + i), '0);
      tick();
      set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
      set_b(1'b1, 1'b0, 1'b0, 5'(20 + i), '0);
      #1;
      chk("t5_rb_rvalid_a", rvalid_a, 1);
      chk("t5_rb_rdata_a", rdata_a, 32'hA000_0000 + 32'(i));
      tick();
      set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
      #1;
      chk("t5_rb_rvalid_b", rvalid_b, 1);
      chk("t5_rb_rdata_b", rdata_b, 32'hB000_0000 + 32'(i));
      tick();
    end

    // A read leaves the tie-break pointing at B
    set_a(1'b1, 1'b0, 1'b0, 5'd1, '0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("a1_rdata_a", rdata_a, 1);
    tick();

    // Reset between a granted locked read and its rvalid cycle
    set_a(1'b1, 1'b0, 1'b1, 5'd3, '0);
    #1;
    chk("t6_gnt_a", gnt_a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_in_rst", gnt_a, 0);
    @(posedge clk);
    #1;
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    rst_n = 1'b1;
    #1;
    chk("t6_rvalid_a", rvalid_a, 0);
    chk("t6_addr", mem_address, 0);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 5'd2, '0);
    set_b(1'b1, 1'b0, 1'b0, 5'd4, '0);
    #1;
    chk("t6_gnt_a2", gnt_a, 1);
    chk("t6_gnt_b2", gnt_b, 0);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 5'd0, '0);
    set_b(1'b0, 1'b0, 1'b0, 5'd0, '0);
    #1;
    chk("t6_rvalid_a2", rvalid_a, 1);
    chk("t6_rdata_a2", rdata_a, 2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter that shares one 32x32 synchronous RAM (5-bit address, 32-bit data, write-first, registered read) between port A and port B.
- Grants at most one RAM access per cycle, round-robin fair.
- Supports a lock for atomic read-modify-write sequences, bounded by MAX_LOCK.
- Sits between the datapath requesters and the RAM instance. The RAM's clk and writeOn, address, data_in and data_out pins connect directly to this block's mem_* ports.

Parameters:
- AW, 5, address width (RAM depth 2^AW = 32).
- DW, 32, data width.
- MAX_LOCK, 4, maximum consecutive cycles a locked port may hold ownership; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  port A access request.
- we_a  in  1  port A write enable (1 = write, 0 = read).
- lock_a  in  1  port A requests to keep ownership after its current access.
- addr_a  in  AW  port A address.
- wdata_a  in  DW  port A write data.
- gnt_a  out  1  port A access accepted this cycle (combinational).
- rvalid_a  out  1  port A read data valid (registered).
- rdata_a  out  DW  port A read data.
- req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B.
- mem_writeOn  out  1  RAM write enable.
- mem_address  out  AW  RAM address.
- mem_data_in  out  DW  RAM write data.
- mem_data_out  in  DW  RAM registered read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=A (A preferred), lock_cnt=0, rvalid_a=rvalid_b=0. Combinational outputs evaluate to gnt=0, mem_writeOn=0, mem_address=0, mem_data_in=0 while in reset.
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE arbitration:
  - Only one req asserted: that port wins.
  - Both asserted: the port selected by rr_ptr wins.
  - After the grant, rr_ptr points to the loser.
- OWN_x (locked): port x always wins if req_x=1, whatever the other request. If req_x=0, arbitrate as in IDLE and return to IDLE.
- Transitions:
  - A grant to x with lock_x=1 and lock_cnt < MAX_LOCK-1 enters or stays in OWN_x and increments lock_cnt.
  - Otherwise go to IDLE with lock_cnt=0.
  - Reaching MAX_LOCK consecutive grants forces IDLE and sets rr_ptr to the other port, even if lock_x stays high (anti-starvation).
- Grant cycle: gnt_x=1 combinationally in the same cycle as req_x. mem_address=addr_x, mem_data_in=wdata_x, mem_writeOn=we_x. The access takes effect at the next posedge. The requester must hold inputs stable until gnt.
- Non-grant cycle: mem_writeOn=0. mem_address and mem_data_in hold their last values, so no spurious write can occur.
- Read latency: 1 cycle. rvalid_x=1 in the cycle after a granted read (we_x=0), with rdata_x=mem_data_out.
- Granted writes never raise rvalid. The RAM's write-first data_out is ignored.
- rdata_a and rdata_b both mirror mem_data_out continuously; they are meaningful only while the matching rvalid is high.
- Back-to-back grants are allowed every cycle. The rvalid pipeline has no gaps or stalls.
- Same-cycle write and later read to the same address from different ports: the write is serialized first, and the read returns the new data.
- Reset mid-operation: in-flight rvalid is dropped. The RAM contents are not touched by this block.

Test Plan:
- Reset then A reads addr 3 (RAM preloaded 0x0000_0003) -> gnt_a same cycle, rvalid_a=1 and rdata_a=0x0000_0003 one cycle later, gnt_b=0.
- req_a and req_b both held for 4 cycles, reads -> grants alternate A,B,A,B; each rvalid follows its gnt by exactly 1 cycle.
- B writes 0xDEAD_BEEF to addr 7 while A reads addr 7 in the same cycle, rr_ptr=B -> B granted first, then A granted, and rdata_a=0xDEAD_BEEF.
- lock_a=1 with req_a and req_b held constant, MAX_LOCK=4 -> A granted 4 consecutive cycles, then B granted, then alternation.
- Write-only traffic -> rvalid_a and rvalid_b stay 0. mem_writeOn=0 on every idle cycle. Data read back afterwards matches what was written.
- rst_n pulsed low between a granted read and its rvalid cycle -> rvalid stays 0, state returns to IDLE, and the next simultaneous request goes to A.
